// File: rtl/ongoru_pkg.sv
// Shared types and default widths for the branch-prediction sequencing controller.
package ongoru_pkg;

  localparam int PC_LEN   = 32;
  localparam int INST_LEN = 32;

  // One in-flight branch record: fetched PC, instruction word and the
  // prediction that was made for it at fetch time.
  typedef struct packed {
    logic [PC_LEN-1:0]   ps;
    logic [INST_LEN-1:0] buyruk;
    logic                tahmin_dallan;
    logic [PC_LEN-1:0]   tahmin_ps;
  } girdi_t;

  // CALIS: normal operation. BOSALT: single recovery cycle after a flush.
  typedef enum logic {
    CALIS  = 1'b0,
    BOSALT = 1'b1
  } durum_t;

endpackage

// File: rtl/ongoru_denetleyici_if.sv
// Fetch / execute / predictor-update signal bundle of the sequencing controller.
interface ongoru_denetleyici_if #(
  parameter int PC_LEN   = ongoru_pkg::PC_LEN,
  parameter int INST_LEN = ongoru_pkg::INST_LEN,
  parameter int CNT_W    = 16
);

  logic                getir_gecerli;
  logic [PC_LEN-1:0]   getir_ps;
  logic [INST_LEN-1:0] getir_buyruk;
  logic                ongoru_dallan;
  logic [PC_LEN-1:0]   ongoru_dallan_ps;
  logic                getir_hazir;

  logic                yurut_gecerli;
  logic [PC_LEN-1:0]   yurut_ps;
  logic                yurut_dallan;
  logic [PC_LEN-1:0]   yurut_dallan_ps;

  logic                guncelle_gecerli;
  logic [PC_LEN-1:0]   guncelle_ps;
  logic [INST_LEN-1:0] guncelle_buyruk;
  logic                guncelle_dallan;
  logic [PC_LEN-1:0]   guncelle_dallan_ps;

  logic                bosalt;
  logic [PC_LEN-1:0]   yonlendir_ps;
  logic [CNT_W-1:0]    toplam_sayac;
  logic [CNT_W-1:0]    hata_sayac;
  logic                sira_hata;

  // Controller side
  modport slave (
    input  getir_gecerli, getir_ps, getir_buyruk, ongoru_dallan, ongoru_dallan_ps,
    input  yurut_gecerli, yurut_ps, yurut_dallan, yurut_dallan_ps,
    output getir_hazir,
    output guncelle_gecerli, guncelle_ps, guncelle_buyruk, guncelle_dallan, guncelle_dallan_ps,
    output bosalt, yonlendir_ps, toplam_sayac, hata_sayac, sira_hata
  );

  // Pipeline / environment side
  modport master (
    output getir_gecerli, getir_ps, getir_buyruk, ongoru_dallan, ongoru_dallan_ps,
    output yurut_gecerli, yurut_ps, yurut_dallan, yurut_dallan_ps,
    input  getir_hazir,
    input  guncelle_gecerli, guncelle_ps, guncelle_buyruk, guncelle_dallan, guncelle_dallan_ps,
    input  bosalt, yonlendir_ps, toplam_sayac, hata_sayac, sira_hata
  );

endinterface

// File: rtl/ongoru_kuyruk.sv
// Synchronous FIFO with push/pop/clear; clear wins over push and pop.
module ongoru_kuyruk #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DOLU_ADET = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] bas;
  logic [AW-1:0] son;
  logic [AW:0]   adet;
  logic          yaz;
  logic          oku;

  assign full  = (adet == DOLU_ADET);
  assign empty = (adet == '0);
  assign count = adet;
  assign dout  = mem[bas];
  assign yaz   = push && !full;
  assign oku   = pop && !empty;

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (yaz) mem[son] <= din;
  end

  // Pointers wrap naturally modulo DEPTH; occupancy tracks push/pop balance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bas  <= '0;
      son  <= '0;
      adet <= '0;
    end else if (clear) begin
      bas  <= '0;
      son  <= '0;
      adet <= '0;
    end else begin
      if (yaz) son <= son + 1'b1;
      if (oku) bas <= bas + 1'b1;
      case ({yaz, oku})
        2'b10:   adet <= adet + 1'b1;
        2'b01:   adet <= adet - 1'b1;
        default: adet <= adet;
      endcase
    end
  end

endmodule

// File: rtl/ongoru_denetleyici.sv
// Branch sequencing controller: in-order in-flight branch tracking, resolution
// check, predictor update strobe, flush/redirect and accuracy counters.
module ongoru_denetleyici
  import ongoru_pkg::*;
#(
  parameter int PC_LEN   = ongoru_pkg::PC_LEN,
  parameter int INST_LEN = ongoru_pkg::INST_LEN,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               rstn,
  ongoru_denetleyici_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = 2 * PC_LEN + INST_LEN + 1;
  localparam logic [AW:0] DOLU_ADET = DEPTH[AW:0];

  typedef struct packed {
    logic [PC_LEN-1:0]   ps;
    logic [INST_LEN-1:0] buyruk;
    logic                tahmin_dallan;
    logic [PC_LEN-1:0]   tahmin_ps;
  } kayit_t;

  kayit_t      giris;
  kayit_t      bas;
  logic        dolu;
  logic        bos;
  logic [AW:0] adet;

  durum_t durum;
  durum_t durum_sonraki;

  logic hazir;
  logic itme;
  logic cekme;
  logic temizle;
  logic cozum_gecerli;
  logic cozum_gecersiz;
  logic yanlis;
  logic [PC_LEN-1:0] dogru_ps;

  logic                guncelle_gecerli;
  logic [PC_LEN-1:0]   guncelle_ps;
  logic [INST_LEN-1:0] guncelle_buyruk;
  logic                guncelle_dallan;
  logic [PC_LEN-1:0]   guncelle_dallan_ps;
  logic                bosalt;
  logic [PC_LEN-1:0]   yonlendir_ps;
  logic [CNT_W-1:0]    toplam;
  logic [CNT_W-1:0]    hata;
  logic                sira_hata;

  assign giris.ps            = bus.getir_ps;
  assign giris.buyruk        = bus.getir_buyruk;
  assign giris.tahmin_dallan = bus.ongoru_dallan;
  assign giris.tahmin_ps     = bus.ongoru_dallan_ps;

  ongoru_kuyruk #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_kuyruk (
    .clk   (clk),
    .rstn  (rstn),
    .push  (itme),
    .pop   (cekme),
    .clear (temizle),
    .din   (giris),
    .dout  (bas),
    .full  (dolu),
    .empty (bos),
    .count (adet)
  );

  assign dogru_ps = bus.yurut_dallan ? bus.yurut_dallan_ps : bus.yurut_ps + PC_LEN'(4);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) durum <= CALIS;
    else       durum <= durum_sonraki;
  end

  // Next state, acceptance and resolution decode; execute inputs are ignored in BOSALT.
  always_comb begin
    durum_sonraki  = durum;
    hazir          = 1'b0;
    itme           = 1'b0;
    cekme          = 1'b0;
    temizle        = 1'b0;
    cozum_gecerli  = 1'b0;
    cozum_gecersiz = 1'b0;
    yanlis         = 1'b0;
    case (durum)
      CALIS: begin
        hazir = (adet < DOLU_ADET);
        itme  = bus.getir_gecerli && hazir;
        if (bus.yurut_gecerli) begin
          if (!bos && (bus.yurut_ps == bas.ps)) begin
            cozum_gecerli = 1'b1;
            cekme         = 1'b1;
            yanlis        = (bus.yurut_dallan != bas.tahmin_dallan) ||
                            (bus.yurut_dallan && (bus.yurut_dallan_ps != bas.tahmin_ps));
            if (yanlis) begin
              temizle       = 1'b1;
              durum_sonraki = BOSALT;
            end
          end else begin
            cozum_gecersiz = 1'b1;
          end
        end
      end
      BOSALT:  durum_sonraki = CALIS;
      default: durum_sonraki = CALIS;
    endcase
  end

  // Predictor update register: one-cycle strobe, payload held between updates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      guncelle_gecerli   <= 1'b0;
      guncelle_ps        <= '0;
      guncelle_buyruk    <= '0;
      guncelle_dallan    <= 1'b0;
      guncelle_dallan_ps <= '0;
    end else begin
      guncelle_gecerli <= cozum_gecerli;
      if (cozum_gecerli) begin
        guncelle_ps        <= bus.yurut_ps;
        guncelle_buyruk    <= bas.buyruk;
        guncelle_dallan    <= bus.yurut_dallan;
        guncelle_dallan_ps <= bus.yurut_dallan_ps;
      end
    end
  end

  // Flush pulse and redirect target.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bosalt       <= 1'b0;
      yonlendir_ps <= '0;
    end else begin
      bosalt <= yanlis;
      if (yanlis) yonlendir_ps <= dogru_ps;
    end
  end

  // Saturating resolved / mispredicted counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      toplam <= '0;
      hata   <= '0;
    end else begin
      if (cozum_gecerli && (toplam != '1)) toplam <= toplam + 1'b1;
      if (yanlis && (hata != '1))          hata   <= hata + 1'b1;
    end
  end

  // Sticky ordering error, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)               sira_hata <= 1'b0;
    else if (cozum_gecersiz) sira_hata <= 1'b1;
  end

  assert property (@(posedge clk) disable iff (!rstn) dolu == (adet == DOLU_ADET));

  assign bus.getir_hazir        = hazir;
  assign bus.guncelle_gecerli   = guncelle_gecerli;
  assign bus.guncelle_ps        = guncelle_ps;
  assign bus.guncelle_buyruk    = guncelle_buyruk;
  assign bus.guncelle_dallan    = guncelle_dallan;
  assign bus.guncelle_dallan_ps = guncelle_dallan_ps;
  assign bus.bosalt             = bosalt;
  assign bus.yonlendir_ps       = yonlendir_ps;
  assign bus.toplam_sayac       = toplam;
  assign bus.hata_sayac         = hata;
  assign bus.sira_hata          = sira_hata;

endmodule

// File: tb/tb_ongoru_denetleyici.sv
// Scoreboard bench for ongoru_denetleyici: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_ongoru_denetleyici;
  import ongoru_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int unsigned MAXC = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ongoru_denetleyici_if #(.PC_LEN(32), .INST_LEN(32), .CNT_W(CNT_W)) bus ();

  ongoru_denetleyici #(
    .PC_LEN   (32),
    .INST_LEN (32),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int unsigned due;
    logic        flush;
    logic [31:0] ps;
    logic [31:0] buyruk;
    logic        dallan;
    logic [31:0] dallan_ps;
    logic [31:0] yon;
  } beklenen_t;

  beklenen_t   sb[$];
  girdi_t      m_q[$];
  bit          m_bosalt;
  int unsigned m_top, m_hata;
  bit          m_sira;
  int unsigned total = 0, bad = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pop the scoreboard whenever an update/flush is presented.
  always @(negedge clk) begin
    beklenen_t e;
    if (rstn) begin
      if (bus.guncelle_gecerli || bus.bosalt) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", {30'b0, bus.guncelle_gecerli, bus.bosalt}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("strobe_cycle", cyc, e.due);
          chk("guncelle_gecerli", {31'b0, bus.guncelle_gecerli}, 32'd1);
          chk("guncelle_ps", bus.guncelle_ps, e.ps);
          chk("guncelle_buyruk", bus.guncelle_buyruk, e.buyruk);
          chk("guncelle_dallan", {31'b0, bus.guncelle_dallan}, {31'b0, e.dallan});
          chk("guncelle_dallan_ps", bus.guncelle_dallan_ps, e.dallan_ps);
          chk("bosalt", {31'b0, bus.bosalt}, {31'b0, e.flush});
          if (e.flush) chk("yonlendir_ps", bus.yonlendir_ps, e.yon);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("missing_strobe", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  // One cycle of stimulus, called at posedge+1; the model state afterwards
  // describes the controller after the coming clock edge.
  task automatic adim(input logic gv, input logic [31:0] gps, input logic [31:0] gbuy,
                      input logic od, input logic [31:0] odps,
                      input logic yv, input logic [31:0] yps,
                      input logic yd, input logic [31:0] ydps);
    bit hz, gecerli, yanlis;
    girdi_t bs, yeni;
    beklenen_t e;
    hz = !m_bosalt && (m_q.size() < DEPTH);
    chk("getir_hazir", {31'b0, bus.getir_hazir}, {31'b0, hz});
    chk("toplam_sayac", {28'b0, bus.toplam_sayac}, m_top);
    chk("hata_sayac", {28'b0, bus.hata_sayac}, m_hata);
    chk("sira_hata", {31'b0, bus.sira_hata}, {31'b0, m_sira});

    bus.getir_gecerli    = gv;
    bus.getir_ps         = gps;
    bus.getir_buyruk     = gbuy;
    bus.ongoru_dallan    = od;
    bus.ongoru_dallan_ps = odps;
    bus.yurut_gecerli    = yv;
    bus.yurut_ps         = yps;
    bus.yurut_dallan     = yd;
    bus.yurut_dallan_ps  = ydps;

    gecerli = 0;
    yanlis  = 0;
    bs      = '0;
    if (!m_bosalt && yv) begin
      if (m_q.size() > 0 && m_q[0].ps == yps) begin
        gecerli = 1;
        bs      = m_q[0];
        yanlis  = (yd != bs.tahmin_dallan) || (yd && ydps != bs.tahmin_ps);
      end else begin
        m_sira = 1;
      end
    end
    if (gecerli) begin
      e.due = cyc + 1; e.flush = yanlis; e.ps = yps; e.buyruk = bs.buyruk;
      e.dallan = yd; e.dallan_ps = ydps; e.yon = yd ? ydps : yps + 32'd4;
      sb.push_back(e);
      void'(m_q.pop_front());
      if (m_top < MAXC) m_top++;
      if (yanlis && m_hata < MAXC) m_hata++;
    end
    if (gv && hz) begin
      yeni.ps = gps; yeni.buyruk = gbuy; yeni.tahmin_dallan = od; yeni.tahmin_ps = odps;
      m_q.push_back(yeni);
    end
    if (yanlis) m_q.delete();
    m_bosalt = yanlis;
    @(posedge clk);
    #1;
  endtask

  task automatic getir(input logic [31:0] ps, input logic od, input logic [31:0] odps);
    adim(1'b1, ps, ps ^ 32'hA5A5_0000, od, odps, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic yurut(input logic [31:0] ps, input logic yd, input logic [31:0] ydps);
    adim(1'b0, '0, '0, 1'b0, '0, 1'b1, ps, yd, ydps);
  endtask

  task automatic bos_adim();
    adim(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic sifir_kontrol();
    chk("rst_guncelle_gecerli", {31'b0, bus.guncelle_gecerli}, 32'd0);
    chk("rst_guncelle_ps", bus.guncelle_ps, 32'd0);
    chk("rst_guncelle_buyruk", bus.guncelle_buyruk, 32'd0);
    chk("rst_guncelle_dallan", {31'b0, bus.guncelle_dallan}, 32'd0);
    chk("rst_guncelle_dallan_ps", bus.guncelle_dallan_ps, 32'd0);
    chk("rst_bosalt", {31'b0, bus.bosalt}, 32'd0);
    chk("rst_yonlendir_ps", bus.yonlendir_ps, 32'd0);
    chk("rst_toplam", {28'b0, bus.toplam_sayac}, 32'd0);
    chk("rst_hata", {28'b0, bus.hata_sayac}, 32'd0);
    chk("rst_sira_hata", {31'b0, bus.sira_hata}, 32'd0);
    chk("rst_getir_hazir", {31'b0, bus.getir_hazir}, 32'd1);
  endtask

  task automatic girisleri_sifirla();
    bus.getir_gecerli = 0; bus.getir_ps = '0; bus.getir_buyruk = '0;
    bus.ongoru_dallan = 0; bus.ongoru_dallan_ps = '0;
    bus.yurut_gecerli = 0; bus.yurut_ps = '0; bus.yurut_dallan = 0; bus.yurut_dallan_ps = '0;
  endtask

  task automatic model_sifirla();
    m_q.delete(); sb.delete();
    m_bosalt = 0; m_top = 0; m_hata = 0; m_sira = 0;
  endtask

  initial begin
    logic        gv, od, yv, yd;
    logic [31:0] gps, odps, yps, ydps;
    girisleri_sifirla();
    model_sifirla();
    #12;
    sifir_kontrol();
    #11 rstn = 1'b1;
    @(posedge clk);
    #1;

    // 1: correct not-taken
    getir(32'h100, 1'b0, 32'h0);
    yurut(32'h100, 1'b0, 32'h0);
    bos_adim();
    // 2: direction mispredict, then the BOSALT cycle
    getir(32'h200, 1'b0, 32'h0);
    yurut(32'h200, 1'b1, 32'h400);
    bos_adim();
    bos_adim();
    // 3: target mispredict; not-taken mispredict at 0x3FC
    getir(32'h300, 1'b1, 32'h340);
    yurut(32'h300, 1'b1, 32'h380);
    bos_adim();
    bos_adim();
    getir(32'h3FC, 1'b1, 32'h500);
    yurut(32'h3FC, 1'b0, 32'h0);
    bos_adim();
    bos_adim();
    // 4: fill, fifth fetch dropped, drain in order
    for (int unsigned i = 0; i < 5; i++) getir(32'h10 + 4 * i, 1'b0, 32'h0);
    for (int unsigned i = 0; i < 4; i++) yurut(32'h10 + 4 * i, 1'b0, 32'h0);
    bos_adim();
    // 5: flush with younger entries and same-cycle enqueue
    getir(32'h40, 1'b0, 32'h0);
    getir(32'h44, 1'b0, 32'h0);
    getir(32'h48, 1'b0, 32'h0);
    adim(1'b1, 32'h4C, 32'h4C4C, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h80);
    bos_adim();
    yurut(32'h44, 1'b0, 32'h0);
    bos_adim();
    // 6: asynchronous reset between edges with entries in flight
    getir(32'h500, 1'b0, 32'h0);
    getir(32'h504, 1'b1, 32'h600);
    getir(32'h508, 1'b0, 32'h0);
    girisleri_sifirla();
    #2 rstn = 1'b0;
    #1;
    model_sifirla();
    sifir_kontrol();
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    getir(32'h700, 1'b0, 32'h0);
    yurut(32'h700, 1'b0, 32'h0);
    bos_adim();

    // Random traffic; small CNT_W makes the counters reach saturation.
    for (int i = 0; i < 3000; i++) begin
      gv   = ($urandom_range(0, 99) < 60);
      gps  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      od   = $urandom_range(0, 1);
      odps = $urandom & 32'hFFFF_FFFC;
      yv   = ($urandom_range(0, 99) < 50);
      if (m_q.size() > 0 && $urandom_range(0, 19) != 0) begin
        yps = m_q[0].ps;
        if ($urandom_range(0, 9) < 7) begin
          yd   = m_q[0].tahmin_dallan;
          ydps = yd ? m_q[0].tahmin_ps : ($urandom & 32'hFFFF_FFFC);
        end else begin
          yd   = $urandom_range(0, 1);
          ydps = ($urandom_range(0, 1) == 1) ? m_q[0].tahmin_ps : ($urandom & 32'hFFFF_FFFC);
        end
      end else begin
        yps  = $urandom & 32'hFFFF_FFFC;
        yd   = $urandom_range(0, 1);
        ydps = $urandom & 32'hFFFF_FFFC;
      end
      adim(gv, gps, $urandom, od, odps, yv, yps, yd, ydps);
    end
    bos_adim();
    bos_adim();
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
